// File: rtl/cpuf_pkg.sv
// Shared CPU-side constants and the program-loader state encoding.
// RAM geometry is shared by the RAM, the MAR and the loader.
package cpuf_pkg;

    localparam int          RAM_AW      = 4;
    localparam int          RAM_DEPTH   = 2 ** RAM_AW;
    localparam logic [7:0]  HDR_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } state_t;

    // True while a frame is being received (the timeout only runs here).
    function automatic logic in_frame(state_t s);
        return (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream plus RAM write port of the program loader.
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready; mem_we is a one-cycle strobe.
interface prog_loader_if
    import cpuf_pkg::*;
#(
    parameter int AW = RAM_AW
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/loader_timer.sv
// Idle-gap down-counter: reloads on clear, counts while enabled,
// and pulses expire_o for the cycle in which the budget runs out.
module loader_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int          TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the same cycle (accepted byte) overrides the expiry.
    assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Frame receiver that writes payload bytes into the CPU RAM and holds the
// CPU in reset until a frame with a matching XOR checksum has been written.
module prog_loader
    import cpuf_pkg::*;
#(
    parameter int          DEPTH   = RAM_DEPTH,
    parameter int          AW      = RAM_AW,
    parameter logic [7:0]  HDR     = HDR_DEFAULT,
    parameter int          TIMEOUT = 1000
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_err,
    output logic          busy,
    output state_t        dbg_state_o
);
    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [7:0]    xor_q, xor_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          hold_q, busy_q;
    logic          acc;
    logic          expire;

    // The loader never back-pressures, so every valid byte is accepted.
    assign acc = bus.in_valid;

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (acc || !in_frame(state_q)),
        .en_i     (in_frame(state_q)),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (acc && (bus.in_data == HDR)) begin
                    state_d = LEN;
                    xor_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LEN: begin
                if (acc) begin
                    if ((bus.in_data == 8'd0) || (bus.in_data > 8'(DEPTH))) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        len_d   = bus.in_data[AW:0];
                        cnt_d   = '0;
                        state_d = DATA;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            DATA: begin
                if (acc) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = bus.in_data;
                    xor_d   = xor_q ^ bus.in_data;
                    cnt_d   = cnt_q + 1'b1;
                    if ({1'b0, cnt_q} == (len_q - 1'b1)) begin
                        state_d = CSUM;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            CSUM: begin
                if (acc) begin
                    if (bus.in_data == xor_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // hold/busy are registered from the next state so they change together with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            xor_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= (state_d != DONE);
            busy_q  <= in_frame(state_d);
        end
    end

    assign bus.in_ready  = 1'b1;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_hold      = hold_q;
    assign load_done     = done_q;
    assign load_err      = err_q;
    assign busy          = busy_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames
// scored against a frame-level reference model.
module tb_prog_loader;
    import cpuf_pkg::*;

    localparam int         TO     = 40;
    localparam logic [7:0] HDR_B  = 8'hA5;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_loader_if #(.AW(RAM_AW)) bus();
    logic   cpu_hold, load_done, load_err, busy;
    state_t dbg_state;

    prog_loader #(
        .DEPTH   (RAM_DEPTH),
        .AW      (RAM_AW),
        .HDR     (HDR_B),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  frame_q[$];
    logic        exp_done, exp_err;

    // scoreboard: every RAM strobe must match the oldest expected {addr,data}
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            logic [11:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got addr=%0h data=%02h exp no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write_data got=%03h exp=%03h", {bus.mem_addr, bus.mem_wdata}, e);
                end
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stray(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == HDR_B) b = 8'h00;
            send_byte(b);
        end
    endtask

    // kind 0 = good, 1 = bad checksum, 2 = bad length
    task automatic make_frame(input int kind);
        int         n;
        logic [7:0] x;
        frame_q.delete();
        frame_q.push_back(HDR_B);
        if (kind == 2) begin
            n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(RAM_DEPTH + 1, 255);
            frame_q.push_back(8'(n));
        end else begin
            n = $urandom_range(1, RAM_DEPTH);
            frame_q.push_back(8'(n));
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                frame_q.push_back(8'($urandom_range(0, 255)));
                x = x ^ frame_q[2 + i];
            end
            if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
            frame_q.push_back(x);
        end
    endtask

    // reference model: frame contents -> expected writes and outcome
    task automatic model_frame();
        int         n;
        logic [7:0] x;
        n        = frame_q[1];
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (n == 0 || n > RAM_DEPTH) begin
            exp_err = 1'b1;
        end else begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({4'(i), frame_q[2 + i]});
                x = x ^ frame_q[2 + i];
            end
            if (frame_q[2 + n] == x) exp_done = 1'b1;
            else                     exp_err  = 1'b1;
        end
    endtask

    task automatic send_frame(input int from, input int max_gap);
        for (int i = from; i < frame_q.size(); i++) begin
            send_byte(frame_q[i]);
            tick($urandom_range(0, max_gap));
        end
    endtask

    // tests
    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        tick(2);
        checks++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 4'h0, 8'h00}) begin
            errors++;
            $display("FAIL reset_bus got=%h exp=%h", {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 13'h0});
        end
        checks++;
        if ({cpu_hold, load_done, load_err, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=1000", {cpu_hold, load_done, load_err, busy});
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_good_frame();
        exp_q.push_back({4'h0, 8'h86});
        exp_q.push_back({4'h1, 8'h45});
        exp_q.push_back({4'h2, 8'h21});
        send_byte(8'hA5);
        checks++;
        if ({cpu_hold, load_done, load_err, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL good_hdr_flags got=%b exp=1001", {cpu_hold, load_done, load_err, busy});
        end
        send_byte(8'h03);
        send_byte(8'h86);
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'h0, 8'h86}) begin
            errors++;
            $display("FAIL good_first_strobe got=%h exp=%h", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 4'h0, 8'h86});
        end
        send_byte(8'h45);
        send_byte(8'h21);
        checks++;
        if ({cpu_hold, load_done, dbg_state} !== {1'b1, 1'b0, CSUM}) begin
            errors++;
            $display("FAIL good_before_csum got=%h exp=%h", {cpu_hold, load_done, dbg_state}, {1'b1, 1'b0, CSUM});
        end
        send_byte(8'hE2);
        checks++;
        if ({cpu_hold, load_done, load_err, busy, bus.mem_we} !== 5'b01000) begin
            errors++;
            $display("FAIL good_done got=%b exp=01000", {cpu_hold, load_done, load_err, busy, bus.mem_we});
        end
        tick(3);
        checks++;
        if ({cpu_hold, load_done, exp_q.size() == 0} !== 3'b011) begin
            errors++;
            $display("FAIL good_settled got=%b exp=011 pending=%0d", {cpu_hold, load_done, exp_q.size() == 0}, exp_q.size());
        end
    endtask

    task automatic test_bad_csum();
        send_byte(8'hA5);
        exp_q.push_back({4'h0, 8'h10});
        exp_q.push_back({4'h1, 8'h20});
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h31);
        tick(1);
        checks++;
        if ({cpu_hold, load_done, load_err, busy, dbg_state} !== {4'b1010, IDLE}) begin
            errors++;
            $display("FAIL badcsum_flags got=%h exp=%h", {cpu_hold, load_done, load_err, busy, dbg_state}, {4'b1010, IDLE});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL badcsum_writes got pending=%0d exp=0", exp_q.size());
        end
        make_frame(0);
        model_frame();
        send_byte(frame_q[0]);
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("FAIL hdr_clears_err got=%b exp=0", load_err);
        end
        send_frame(1, 2);
        checks++;
        if ({cpu_hold, load_done, load_err, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL recover_good got=%b exp=0100", {cpu_hold, load_done, load_err, busy});
        end
    endtask

    task automatic test_len();
        logic [7:0] bad_len[2];
        bad_len[0] = 8'h00;
        bad_len[1] = 8'h11;
        for (int i = 0; i < 2; i++) begin
            send_byte(8'hA5);
            send_byte(bad_len[i]);
            tick(1);
            checks++;
            if ({cpu_hold, load_done, load_err, busy, dbg_state, bus.mem_we} !== {4'b1010, IDLE, 1'b0}) begin
                errors++;
                $display("FAIL len_%02h got=%h exp=%h", bad_len[i],
                         {cpu_hold, load_done, load_err, busy, dbg_state, bus.mem_we}, {4'b1010, IDLE, 1'b0});
            end
        end
        // largest legal payload fills the whole RAM
        make_frame(0);
        frame_q.delete();
        frame_q.push_back(HDR_B);
        frame_q.push_back(8'(RAM_DEPTH));
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i < RAM_DEPTH; i++) begin
                frame_q.push_back(8'($urandom_range(0, 255)));
                x = x ^ frame_q[2 + i];
            end
            frame_q.push_back(x);
        end
        model_frame();
        send_frame(0, 1);
        checks++;
        if ({cpu_hold, load_done, load_err, busy, exp_q.size() == 0} !== 5'b01001) begin
            errors++;
            $display("FAIL len_max got=%b exp=01001", {cpu_hold, load_done, load_err, busy, exp_q.size() == 0});
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        send_byte(8'h02);
        exp_q.push_back({4'h0, 8'h10});
        send_byte(8'h10);
        tick(TO - 1);
        checks++;
        if ({cpu_hold, load_done, load_err, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL timeout_early got=%b exp=1001", {cpu_hold, load_done, load_err, busy});
        end
        tick(1);
        checks++;
        if ({cpu_hold, load_done, load_err, busy, dbg_state} !== {4'b1010, IDLE}) begin
            errors++;
            $display("FAIL timeout_abort got=%h exp=%h", {cpu_hold, load_done, load_err, busy, dbg_state}, {4'b1010, IDLE});
        end
        // byte arriving on the last allowed cycle wins over the timeout
        send_byte(8'hA5);
        send_byte(8'h02);
        exp_q.push_back({4'h0, 8'h10});
        send_byte(8'h10);
        tick(TO - 1);
        exp_q.push_back({4'h1, 8'h20});
        send_byte(8'h20);
        checks++;
        if ({load_err, busy, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b0, 1'b1, 1'b1, 4'h1, 8'h20}) begin
            errors++;
            $display("FAIL timeout_race got=%h exp=%h", {load_err, busy, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                     {1'b0, 1'b1, 1'b1, 4'h1, 8'h20});
        end
        send_byte(8'h30);
        checks++;
        if ({cpu_hold, load_done, load_err, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_race_done got=%b exp=0100", {cpu_hold, load_done, load_err, busy});
        end
        // timeout while waiting for the length byte
        send_byte(8'hA5);
        tick(TO);
        checks++;
        if ({cpu_hold, load_done, load_err, busy} !== 4'b1010) begin
            errors++;
            $display("FAIL timeout_len got=%b exp=1010", {cpu_hold, load_done, load_err, busy});
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5);
        send_byte(8'h04);
        exp_q.push_back({4'h0, 8'hB0});
        send_byte(8'hB0);
        // reset coincides with an accepted data byte: no strobe may follow it
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC0;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold, load_done, load_err, busy, dbg_state} !==
            {1'b0, 4'h0, 8'h00, 4'b1000, IDLE}) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h",
                     {bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold, load_done, load_err, busy, dbg_state},
                     {1'b0, 4'h0, 8'h00, 4'b1000, IDLE});
        end
        reset = 1'b0;
        tick(1);
        send_stray(6);
        tick(1);
        checks++;
        if ({cpu_hold, load_done, load_err, busy, dbg_state, exp_q.size() == 0} !== {4'b1000, IDLE, 1'b1}) begin
            errors++;
            $display("FAIL stray_ignored got=%h exp=%h",
                     {cpu_hold, load_done, load_err, busy, dbg_state, exp_q.size() == 0}, {4'b1000, IDLE, 1'b1});
        end
    endtask

    task automatic test_reload();
        make_frame(0);
        model_frame();
        send_frame(0, 1);
        send_stray(3);
        checks++;
        if ({cpu_hold, load_done} !== 2'b01) begin
            errors++;
            $display("FAIL reload_first got=%b exp=01", {cpu_hold, load_done});
        end
        make_frame(0);
        model_frame();
        send_byte(frame_q[0]);
        checks++;
        if ({cpu_hold, load_done, load_err, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL reload_hold got=%b exp=1001", {cpu_hold, load_done, load_err, busy});
        end
        send_frame(1, 2);
        checks++;
        if ({cpu_hold, load_done, load_err, busy, exp_q.size() == 0} !== 5'b01001) begin
            errors++;
            $display("FAIL reload_second got=%b exp=01001", {cpu_hold, load_done, load_err, busy, exp_q.size() == 0});
        end
    endtask

    task automatic test_random();
        int kind;
        for (int it = 0; it < 40; it++) begin
            send_stray($urandom_range(0, 2));
            kind = $urandom_range(0, 2);
            make_frame(kind);
            model_frame();
            send_frame(0, 3);
            tick(2);
            checks++;
            if ({cpu_hold, load_done, load_err, busy} !== {!exp_done, exp_done, exp_err, 1'b0}) begin
                errors++;
                $display("FAIL random_%0d kind=%0d got=%b exp=%b", it, kind,
                         {cpu_hold, load_done, load_err, busy}, {!exp_done, exp_done, exp_err, 1'b0});
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL random_writes_%0d got pending=%0d exp=0", it, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_len();
        test_timeout();
        test_reset_mid();
        test_reload();
        test_random();
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side writer for the CPU's 16x8 program/data RAM.
- Receives a framed byte stream on a valid/ready interface and writes each payload byte into RAM through a one-cycle write strobe.
- Holds the CPU in reset until a frame with a correct checksum has been fully written, then releases it.
- Sits between the host link (UART/byte source) and the RAM write port; it is the writer counterpart of the CPU's fetch/read path.

Parameters:
- DEPTH, 16, number of RAM bytes; maximum payload length.
- AW, 4, RAM address width; DEPTH = 2**AW.
- HDR, 8'hA5, frame start byte.
- TIMEOUT, 1000, idle cycles allowed between bytes inside a frame before abort; must be ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts the byte; transfer occurs when in_valid && in_ready on a rising clk edge.
- mem_we  out  1  RAM write strobe, one cycle per payload byte.
- mem_addr  out  AW  RAM write address.
- mem_wdata  out  8  RAM write data.
- cpu_hold  out  1  drives the CPU reset; 1 = CPU held.
- load_done  out  1  sticky: last frame loaded with a good checksum.
- load_err  out  1  sticky: last frame aborted (bad length, bad checksum, or timeout).
- busy  out  1  frame in progress (state LEN, DATA or CSUM).

Behaviour:
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, busy=0, byte counter=0, running XOR=0, timer=0.
- in_ready is 1 in every state; the loader never back-pressures.
- All outputs are registered.
- States and transitions (evaluated only on an accepted byte unless noted):
  - IDLE: byte==HDR -> LEN, clear load_err/load_done, XOR=0. Any other byte is dropped.
  - LEN: N=byte. N==0 or N>DEPTH -> IDLE with load_err=1. Otherwise store N, counter=0 -> DATA.
  - DATA: register mem_we=1, mem_addr=counter, mem_wdata=byte; the strobe is visible on the cycle after acceptance and lasts exactly one cycle. XOR ^= byte, counter++. When counter reaches N-1 on this byte -> CSUM.
  - CSUM: byte==XOR -> DONE with load_done=1 and cpu_hold=0 on the next cycle. Mismatch -> IDLE with load_err=1 and cpu_hold remaining 1.
  - DONE: byte==HDR -> LEN, cpu_hold=1 on the next cycle, load_done cleared. Other bytes are dropped and the CPU keeps running.
- Timeout:
  - The timer runs only in LEN, DATA and CSUM.
  - It clears on every accepted byte.
  - When it reaches TIMEOUT-1 with no byte accepted -> IDLE with load_err=1.
  - A byte accepted in the same cycle wins over the timeout.
- Counter is AW bits. The N ≤ DEPTH check guarantees no address wrap.
- An aborted frame leaves already-written bytes in RAM; this is not rolled back.
- The loader never writes RAM outside DATA.
- cpu_hold is 1 in every state except DONE.
- Reset mid-frame: immediate return to reset values. A pending mem_we is cancelled on the reset cycle.

Decomposition:
- Shared package cpuf_pkg: state enum {IDLE, LEN, DATA, CSUM, DONE}, HDR default constant, RAM AW/DEPTH constants (shared with the RAM and MAR).
- One natural sub-module, loader_timer: a parameterised clear/enable down-counter with a single-cycle expire pulse.

Test Plan:
- Good frame A5,03,86,45,21,E2 -> mem_we pulses at addr 0,1,2 with data 86,45,21. Then load_done=1, cpu_hold=0 one cycle after the E2 byte, load_err=0.
- Bad checksum A5,02,10,20,31 -> two writes occur, then load_err=1, load_done=0, cpu_hold=1, state IDLE. A following good frame clears load_err.
- Length checks A5,00 and A5,11 -> load_err=1, no mem_we asserted, back in IDLE.
- Timeout A5,02,10 then idle TIMEOUT cycles -> load_err=1 on cycle TIMEOUT after the 10 byte, cpu_hold=1. A byte on exactly cycle TIMEOUT-1 is accepted instead.
- Reset asserted in DATA after 1 of 4 bytes -> all outputs return to reset values next cycle. Stray non-HDR bytes in IDLE are ignored.
- Reload: after a good load, send A5 -> cpu_hold=1 next cycle, load_done=0. A second good frame re-releases the CPU.
